rv_scoreboard: RTL and testbench

Tracks in-flight register writes whose results are not forwardable until writeback, such as loads and CSR reads, and stalls the issue stage when an instruction reads one of them. It sits at the issue/decode boundary. It is the producer-side counterpart of the hazard/forwarding selector. Pending state is set at issue and cleared at writeback, so the forwarding mux only ever receives operands that already exist on the write or write-back path.

---
 rtl/rv_scoreboard_pkg.sv | 9 +
 rtl/rv_scoreboard_if.sv | 41 ++++
 rtl/rv_sb_counter.sv | 36 +++
 rtl/rv_scoreboard.sv | 78 +++++++
 tb/tb_rv_scoreboard.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/rv_scoreboard_pkg.sv
// Shared sizing constants for the late-write scoreboard.
// Register index width is fixed by the 5-bit register fields of the ISA.
package rv_scoreboard_pkg;

  localparam int REGS_DEF  = 32;
  localparam int REG_AW    = 5;
  localparam int CNT_W_DEF = 2;

endpackage

// File: rtl/rv_scoreboard_if.sv
// Issue-stage / writeback bundle between the pipeline and the scoreboard.
// The master is the pipeline control, and the slave is rv_scoreboard.
interface rv_scoreboard_if
  import rv_scoreboard_pkg::*;
#(
  parameter int REGS = REGS_DEF
);

  logic              i_issue_valid;
  logic              i_issue_reg_write;
  logic              i_issue_late;
  logic [REG_AW-1:0] i_issue_rd;
  logic [REG_AW-1:0] i_rs1;
  logic [REG_AW-1:0] i_rs2;
  logic              i_rs1_used;
  logic              i_rs2_used;
  logic              i_wb_valid;
  logic              i_wb_late;
  logic [REG_AW-1:0] i_wb_rd;
  logic              i_flush;
  logic              o_stall;
  logic              o_issue_ready;
  logic [REGS-1:0]   o_pending;
  logic              o_busy;
  logic              o_err;

  modport master (
    output i_issue_valid, i_issue_reg_write, i_issue_late, i_issue_rd,
           i_rs1, i_rs2, i_rs1_used, i_rs2_used,
           i_wb_valid, i_wb_late, i_wb_rd, i_flush,
    input  o_stall, o_issue_ready, o_pending, o_busy, o_err
  );

  modport slave (
    input  i_issue_valid, i_issue_reg_write, i_issue_late, i_issue_rd,
           i_rs1, i_rs2, i_rs1_used, i_rs2_used,
           i_wb_valid, i_wb_late, i_wb_rd, i_flush,
    output o_stall, o_issue_ready, o_pending, o_busy, o_err
  );

endinterface

// File: rtl/rv_sb_counter.sv
// Saturating up/down counter of outstanding late writes for one register.
// The caller guarantees inc is never raised while full without a matching dec.
module rv_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             nz,
  output logic             full,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] MAX = '1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of evaluation order.
  always_ff @(posedge i_clk) begin
    if (i_reset || clr) begin
      count <= '0;
    end else if (inc && !dec) begin
      count <= count + CNT_W'(1);
    end else if (dec && !inc && nz) begin
      count <= count - CNT_W'(1);
    end
  end

  assign nz        = |count;
  assign full      = (count == MAX);
  // A retire with nothing outstanding is reported rather than wrapping.
  assign underflow = dec && !inc && !nz && !clr;

endmodule

// File: rtl/rv_scoreboard.sv
// Late-write scoreboard: counts in-flight load/CSR writes per register and
// stalls issue on a RAW hazard or when the destination counter is saturated.
module rv_scoreboard
  import rv_scoreboard_pkg::*;
#(
  parameter int REGS  = REGS_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_reset,
  rv_scoreboard_if.slave   sb
);

  logic [CNT_W-1:0] cnt [REGS];
  logic [REGS-1:0]  nz;
  logic [REGS-1:0]  full;
  logic [REGS-1:0]  uflow;

  logic wb_hit;
  logic ret_rs1, ret_rs2, ret_rd;
  logic hit_rs1, hit_rs2;
  logic full_rd;
  logic stall, ready, inc;
  logic err_q;

  // A late retire counts only for a real register; x0 is never tracked.
  assign wb_hit  = sb.i_wb_valid && sb.i_wb_late && (sb.i_wb_rd != '0);
  assign ret_rs1 = wb_hit && (sb.i_wb_rd == sb.i_rs1);
  assign ret_rs2 = wb_hit && (sb.i_wb_rd == sb.i_rs2);
  assign ret_rd  = wb_hit && (sb.i_wb_rd == sb.i_issue_rd);

  // Same-cycle retire bypass: the write stage forwards the retiring value.
  assign hit_rs1 = sb.i_rs1_used && (sb.i_rs1 != '0) && (cnt[sb.i_rs1] != CNT_W'(ret_rs1));
  assign hit_rs2 = sb.i_rs2_used && (sb.i_rs2 != '0) && (cnt[sb.i_rs2] != CNT_W'(ret_rs2));

  assign full_rd = full[sb.i_issue_rd] && !ret_rd;
  assign stall   = sb.i_issue_valid && (hit_rs1 || hit_rs2);
  assign ready   = !stall && !(sb.i_issue_reg_write && sb.i_issue_late && full_rd);
  assign inc     = sb.i_issue_valid && ready && sb.i_issue_reg_write &&
                   sb.i_issue_late && (sb.i_issue_rd != '0);

  for (genvar r = 0; r < REGS; r++) begin : g_reg
    if (r == 0) begin : g_zero
      assign cnt[r]   = '0;
      assign nz[r]    = 1'b0;
      assign full[r]  = 1'b0;
      assign uflow[r] = 1'b0;
    end else begin : g_cnt
      rv_sb_counter #(.CNT_W(CNT_W)) u_cnt (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .inc       (inc && (sb.i_issue_rd == REG_AW'(r))),
        .dec       (wb_hit && (sb.i_wb_rd == REG_AW'(r))),
        .clr       (sb.i_flush),
        .count     (cnt[r]),
        .nz        (nz[r]),
        .full      (full[r]),
        .underflow (uflow[r])
      );
    end
  end

  // Sticky error survives flush; only reset clears it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      err_q <= 1'b0;
    end else if (|uflow) begin
      err_q <= 1'b1;
    end
  end

  assign sb.o_stall       = stall;
  assign sb.o_issue_ready = ready;
  assign sb.o_pending     = nz;
  assign sb.o_busy        = |nz;
  assign sb.o_err         = err_q;

endmodule

// File: tb/tb_rv_scoreboard.sv
// Self-checking bench for rv_scoreboard: directed scenarios plus randomized
// traffic compared against a per-register outstanding-count model.
module tb_rv_scoreboard;

  localparam int REGS    = 32;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst;

  rv_scoreboard_if #(.REGS(REGS)) sb_if ();

  rv_scoreboard #(.REGS(REGS), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .sb      (sb_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_cnt  [REGS];
  int m_next [REGS];
  bit m_err;
  bit m_err_next;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    rst                     = 1'b0;
    sb_if.i_issue_valid     = 1'b0;
    sb_if.i_issue_reg_write = 1'b0;
    sb_if.i_issue_late      = 1'b0;
    sb_if.i_issue_rd        = '0;
    sb_if.i_rs1             = '0;
    sb_if.i_rs2             = '0;
    sb_if.i_rs1_used        = 1'b0;
    sb_if.i_rs2_used        = 1'b0;
    sb_if.i_wb_valid        = 1'b0;
    sb_if.i_wb_late         = 1'b0;
    sb_if.i_wb_rd           = '0;
    sb_if.i_flush           = 1'b0;
  endtask

  task automatic set_issue(input bit v, input bit w, input bit l, input int rd);
    sb_if.i_issue_valid     = v;
    sb_if.i_issue_reg_write = w;
    sb_if.i_issue_late      = l;
    sb_if.i_issue_rd        = 5'(rd);
  endtask

  task automatic set_src(input int rs1, input bit u1, input int rs2, input bit u2);
    sb_if.i_rs1      = 5'(rs1);
    sb_if.i_rs1_used = u1;
    sb_if.i_rs2      = 5'(rs2);
    sb_if.i_rs2_used = u2;
  endtask

  task automatic set_wb(input bit v, input bit l, input int rd);
    sb_if.i_wb_valid = v;
    sb_if.i_wb_late  = l;
    sb_if.i_wb_rd    = 5'(rd);
  endtask

  // Sample at the falling edge: compare against the model, then compute the
  // model's post-edge state from this cycle's inputs.
  task automatic cyc_begin();
    int ret [REGS];
    int rd, rs1, rs2;
    bit h1, h2, full_rd, do_inc, e_stall, e_ready;
    logic [31:0] e_pend;
    @(negedge clk);
    rd  = int'(sb_if.i_issue_rd);
    rs1 = int'(sb_if.i_rs1);
    rs2 = int'(sb_if.i_rs2);
    for (int r = 0; r < REGS; r++)
      ret[r] = (sb_if.i_wb_valid && sb_if.i_wb_late && int'(sb_if.i_wb_rd) == r && r != 0) ? 1 : 0;
    h1      = sb_if.i_rs1_used && rs1 != 0 && (m_cnt[rs1] - ret[rs1]) != 0;
    h2      = sb_if.i_rs2_used && rs2 != 0 && (m_cnt[rs2] - ret[rs2]) != 0;
    e_stall = sb_if.i_issue_valid && (h1 || h2);
    full_rd = (m_cnt[rd] == CNT_MAX) && (ret[rd] == 0);
    e_ready = !e_stall && !(sb_if.i_issue_reg_write && sb_if.i_issue_late && full_rd);
    do_inc  = sb_if.i_issue_valid && e_ready && sb_if.i_issue_reg_write &&
              sb_if.i_issue_late && rd != 0;
    e_pend  = '0;
    for (int r = 0; r < REGS; r++) e_pend[r] = (m_cnt[r] != 0);

    check("stall",   32'(sb_if.o_stall),       32'(e_stall));
    check("ready",   32'(sb_if.o_issue_ready), 32'(e_ready));
    check("pending", sb_if.o_pending,          e_pend);
    check("busy",    32'(sb_if.o_busy),        32'(e_pend != 0));
    check("err",     32'(sb_if.o_err),         32'(m_err));

    m_err_next = m_err;
    for (int r = 0; r < REGS; r++) m_next[r] = m_cnt[r];
    if (rst) begin
      for (int r = 0; r < REGS; r++) m_next[r] = 0;
      m_err_next = 1'b0;
    end else if (sb_if.i_flush) begin
      for (int r = 0; r < REGS; r++) m_next[r] = 0;
    end else begin
      for (int r = 1; r < REGS; r++) begin
        bit i;
        i = do_inc && (rd == r);
        if (i && ret[r] != 0) m_next[r] = m_cnt[r];
        else if (i) m_next[r] = m_cnt[r] + 1;
        else if (ret[r] != 0) begin
          if (m_cnt[r] > 0) m_next[r] = m_cnt[r] - 1;
          else m_err_next = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc_end();
    @(posedge clk);
    for (int r = 0; r < REGS; r++) m_cnt[r] = m_next[r];
    m_err = m_err_next;
    #1;
  endtask

  task automatic cycle();
    cyc_begin();
    cyc_end();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < REGS; r++) m_cnt[r] = 0;
    m_err = 1'b0;
    idle();

    // Reset state
    cyc_begin();
    check("rst_pending", sb_if.o_pending, 32'h0);
    check("rst_busy",    32'(sb_if.o_busy),  32'h0);
    check("rst_stall",   32'(sb_if.o_stall), 32'h0);
    check("rst_err",     32'(sb_if.o_err),   32'h0);
    cyc_end();

    // Load-use on x5
    idle(); set_issue(1, 1, 1, 5);
    cyc_begin(); check("lu_ready_n", 32'(sb_if.o_issue_ready), 32'h1); cyc_end();
    idle(); set_issue(1, 1, 0, 1); set_src(5, 1, 0, 0);
    cyc_begin();
    check("lu_stall_n1", 32'(sb_if.o_stall),      32'h1);
    check("lu_pend_n1",  32'(sb_if.o_pending[5]), 32'h1);
    cyc_end();
    cycle();
    set_wb(1, 1, 5);
    cyc_begin(); check("lu_stall_n3", 32'(sb_if.o_stall), 32'h0); cyc_end();
    idle();
    cyc_begin(); check("lu_pend_n4", 32'(sb_if.o_pending[5]), 32'h0); cyc_end();

    // x0 never tracked; unused source ignored
    idle(); set_issue(1, 1, 1, 0); cycle();
    idle();
    cyc_begin(); check("x0_pending", sb_if.o_pending, 32'h0); cyc_end();
    set_issue(1, 1, 1, 5); cycle();
    idle(); set_issue(1, 0, 0, 0); set_src(0, 0, 5, 0);
    cyc_begin(); check("unused_rs2", 32'(sb_if.o_stall), 32'h0); cyc_end();
    idle(); set_wb(1, 1, 5); cycle();

    // Saturation on x7
    idle(); set_issue(1, 1, 1, 7);
    repeat (3) cycle();
    cyc_begin();
    check("sat_ready", 32'(sb_if.o_issue_ready), 32'h0);
    check("sat_stall", 32'(sb_if.o_stall),       32'h0);
    cyc_end();
    set_wb(1, 1, 7);
    cyc_begin(); check("sat_ret_ready", 32'(sb_if.o_issue_ready), 32'h1); cyc_end();
    set_wb(0, 0, 0);
    cyc_begin(); check("sat_still_full", 32'(sb_if.o_issue_ready), 32'h0); cyc_end();
    idle(); set_wb(1, 1, 7);
    repeat (3) cycle();
    idle();
    cyc_begin(); check("sat_drained", 32'(sb_if.o_pending[7]), 32'h0); cyc_end();

    // Same-cycle issue and retire on x9
    idle(); set_issue(1, 1, 1, 9); cycle();
    set_src(9, 1, 0, 0); set_wb(1, 1, 9);
    cyc_begin();
    check("same_stall", 32'(sb_if.o_stall),       32'h0);
    check("same_ready", 32'(sb_if.o_issue_ready), 32'h1);
    cyc_end();
    idle(); set_wb(1, 1, 9);
    cyc_begin(); check("same_cnt1", 32'(sb_if.o_pending[9]), 32'h1); cyc_end();
    idle();
    cyc_begin(); check("same_cleared", 32'(sb_if.o_pending[9]), 32'h0); cyc_end();

    // Flush with x3/x4 pending and a concurrent issue to x6
    idle(); set_issue(1, 1, 1, 3); cycle();
    set_issue(1, 1, 1, 4); cycle();
    set_issue(1, 1, 1, 6); sb_if.i_flush = 1'b1; cycle();
    idle();
    cyc_begin(); check("flush_pending", sb_if.o_pending, 32'h0); cyc_end();

    // Underflow, sticky across flush, cleared by reset
    idle(); set_wb(1, 1, 12); cycle();
    idle();
    cyc_begin(); check("uflow_err", 32'(sb_if.o_err), 32'h1); cyc_end();
    sb_if.i_flush = 1'b1; cycle();
    idle();
    cyc_begin(); check("uflow_sticky", 32'(sb_if.o_err), 32'h1); cyc_end();
    set_issue(1, 1, 1, 2); rst = 1'b1; cycle();
    idle();
    cyc_begin();
    check("rst2_err",     32'(sb_if.o_err),     32'h0);
    check("rst2_pending", sb_if.o_pending,      32'h0);
    check("rst2_busy",    32'(sb_if.o_busy),    32'h0);
    cyc_end();

    // Randomized traffic, registers concentrated on x0..x7 to create hazards
    for (int n = 0; n < 3000; n++) begin
      int lim;
      lim = ($urandom_range(0, 7) == 0) ? 31 : 7;
      idle();
      set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, lim));
      set_src($urandom_range(0, lim), $urandom_range(0, 1) == 1,
              $urandom_range(0, lim), $urandom_range(0, 1) == 1);
      set_wb($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, lim));
      sb_if.i_flush = ($urandom_range(0, 63) == 0);
      rst           = ($urandom_range(0, 255) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
